// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-memory port for loads/stores, stalls upstream
// while a request is outstanding, and owns the MEM/WB pipeline register.
module mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [63:0] alu_result,
   input  logic [63:0] write_data,
   input  logic [4:0]  rd,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        reg_write,
   input  logic        byte_op,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [63:0] dmem_addr,
   output logic [63:0] dmem_wdata,
   output logic [7:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [63:0] dmem_rdata,
   output logic        stall_mem,
   output logic [4:0]  fwd_mem_rd,
   output logic        fwd_mem_ok,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd,
   output logic [63:0] wb_data,
   output logic        err_misalign,
   output logic        err_timeout
);

   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_nxt;

   logic            r_wb_valid;
   logic            r_wb_reg_write;
   logic [4:0]      r_wb_rd;
   logic [63:0]     r_wb_data;
   logic            r_err_misalign;
   logic            r_err_timeout;

   logic            w_mem_op;
   logic            w_misalign;
   logic            w_timeout_hit;
   logic [63:0]     w_rdata_shift;
   logic [63:0]     w_load_val;

   assign w_mem_op      = in_valid & (mem_read | mem_write);
   assign w_misalign    = w_mem_op & ~byte_op & (alu_result[2:0] != 3'b000);
   assign dmem_req      = w_mem_op & ~w_misalign & ~reset;
   assign w_timeout_hit = dmem_req & ~dmem_ack & (r_count == CW'(TIMEOUT - 1));
   assign stall_mem     = dmem_req & ~dmem_ack & ~w_timeout_hit;

   // Port fields come straight from the EX/MEM register, which the stall keeps frozen.
   assign dmem_we    = in_valid & mem_write;
   assign dmem_addr  = {alu_result[63:3], 3'b000};
   assign dmem_be    = byte_op ? (8'b1 << alu_result[2:0]) : 8'hFF;
   assign dmem_wdata = byte_op ? {8{write_data[7:0]}} : write_data;

   assign w_rdata_shift = dmem_rdata >> {alu_result[2:0], 3'b000};

   always_comb begin
      if (w_timeout_hit)
         w_load_val = 64'd0;
      else if (byte_op)
         w_load_val = {56'd0, w_rdata_shift[7:0]};
      else
         w_load_val = dmem_rdata;
   end

   assign fwd_mem_rd = rd;
   assign fwd_mem_ok = in_valid & reg_write & ~mem_read;

   // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      case (r_state)
         S_IDLE: begin
            w_count_nxt = '0;
            if (stall_mem) begin
               w_state_nxt = S_WAIT;
               w_count_nxt = r_count + 1'b1;
            end
         end
         S_WAIT: begin
            if (stall_mem) begin
               w_count_nxt = r_count + 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
               w_count_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers sample together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   // A stalled cycle pushes a bubble; data and rd hold so WB forwarding stays coherent.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wb_valid     <= 1'b0;
         r_wb_reg_write <= 1'b0;
         r_wb_rd        <= 5'd0;
         r_wb_data      <= 64'd0;
      end else if (stall_mem) begin
         r_wb_valid     <= 1'b0;
         r_wb_reg_write <= 1'b0;
      end else begin
         r_wb_valid     <= in_valid;
         r_wb_reg_write <= in_valid & reg_write & ~w_misalign;
         r_wb_rd        <= rd;
         r_wb_data      <= mem_read ? w_load_val : alu_result;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err_misalign <= 1'b0;
         r_err_timeout  <= 1'b0;
      end else begin
         if (w_misalign)
            r_err_misalign <= 1'b1;
         if (w_timeout_hit)
            r_err_timeout <= 1'b1;
      end
   end

   assign wb_valid     = r_wb_valid;
   assign wb_reg_write = r_wb_reg_write;
   assign wb_rd        = r_wb_rd;
   assign wb_data      = r_wb_data;
   assign err_misalign = r_err_misalign;
   assign err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, waited load, byte store/load,
// misalignment, timeout with stray ack, and reset during an outstanding request.
module tb_mem_stage;

   localparam int TIMEOUT = 16;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [63:0] alu_result;
   logic [63:0] write_data;
   logic [4:0]  rd;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic        byte_op;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_be;
   logic        dmem_ack;
   logic [63:0] dmem_rdata;
   logic        stall_mem;
   logic [4:0]  fwd_mem_rd;
   logic        fwd_mem_ok;
   logic        wb_valid;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        err_misalign;
   logic        err_timeout;

   int total = 0;
   int bad   = 0;

   mem_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .alu_result(alu_result),
      .write_data(write_data), .rd(rd), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .byte_op(byte_op), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
      .fwd_mem_rd(fwd_mem_rd), .fwd_mem_ok(fwd_mem_ok), .wb_valid(wb_valid),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .err_misalign(err_misalign), .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish exp finish before 100us");
      $fatal(1);
   end

   task automatic idle();
      @(negedge clk);
      in_valid = 0; mem_read = 0; mem_write = 0; reg_write = 0; byte_op = 0; dmem_ack = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1; in_valid = 1; mem_read = 1; mem_write = 0; reg_write = 1; byte_op = 0;
      alu_result = 64'h40; write_data = 0; rd = 1; dmem_ack = 0; dmem_rdata = 0;
      #2;
      total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b exp 0", dmem_req); end
      total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b exp 0", stall_mem); end
      @(posedge clk); #1;
      total++; if ({wb_valid, wb_reg_write, wb_rd} !== 7'd0) begin bad++; $display("FAIL rst_wb_ctl: got %h exp 0", {wb_valid, wb_reg_write, wb_rd}); end
      total++; if (wb_data !== 64'd0) begin bad++; $display("FAIL rst_wb_data: got %h exp 0", wb_data); end
      total++; if ({err_misalign, err_timeout} !== 2'b00) begin bad++; $display("FAIL rst_err: got %b exp 00", {err_misalign, err_timeout}); end
      @(negedge clk);
      in_valid = 0; mem_read = 0; reg_write = 0;
      reset = 0;
   endtask

   task automatic test_add();
      @(negedge clk);
      in_valid = 1; alu_result = 64'h2A; rd = 3; reg_write = 1; mem_read = 0; mem_write = 0; byte_op = 0;
      #1;
      total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL add_stall: got %b exp 0", stall_mem); end
      total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL add_req: got %b exp 0", dmem_req); end
      total++; if (fwd_mem_ok !== 1'b1) begin bad++; $display("FAIL add_fwd_ok: got %b exp 1", fwd_mem_ok); end
      total++; if (fwd_mem_rd !== 5'd3) begin bad++; $display("FAIL add_fwd_rd: got %0d exp 3", fwd_mem_rd); end
      @(posedge clk); #1;
      total++; if ({wb_valid, wb_reg_write} !== 2'b11) begin bad++; $display("FAIL add_wb_ctl: got %b exp 11", {wb_valid, wb_reg_write}); end
      total++; if (wb_rd !== 5'd3) begin bad++; $display("FAIL add_wb_rd: got %0d exp 3", wb_rd); end
      total++; if (wb_data !== 64'h2A) begin bad++; $display("FAIL add_wb_data: got %h exp 2a", wb_data); end
   endtask

   // Ack arrives 3 cycles after the first request cycle.
   task automatic test_load_wait();
      int stalls = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) begin
            in_valid = 1; alu_result = 64'h40; rd = 5; reg_write = 1; mem_read = 1; byte_op = 0;
            dmem_rdata = 64'hFFFF_0000_FFFF_0000;
         end
         dmem_ack = (i == 3);
         if (i == 3) dmem_rdata = 64'h1122334455667788;
         #1;
         if (stall_mem === 1'b1) stalls++;
         total++; if (stall_mem !== (i < 3)) begin bad++; $display("FAIL ld_stall_%0d: got %b exp %b", i, stall_mem, i < 3); end
         total++; if ({dmem_req, dmem_we} !== 2'b10) begin bad++; $display("FAIL ld_req_%0d: got %b exp 10", i, {dmem_req, dmem_we}); end
         total++; if (fwd_mem_ok !== 1'b0) begin bad++; $display("FAIL ld_fwd_ok_%0d: got %b exp 0", i, fwd_mem_ok); end
         if (i == 0) begin
            total++; if (dmem_addr !== 64'h40) begin bad++; $display("FAIL ld_addr: got %h exp 40", dmem_addr); end
            total++; if (dmem_be !== 8'hFF) begin bad++; $display("FAIL ld_be: got %h exp ff", dmem_be); end
         end
         @(posedge clk); #1;
         if (i < 3) begin
            total++; if ({wb_valid, wb_reg_write} !== 2'b00) begin bad++; $display("FAIL ld_bubble_%0d: got %b exp 00", i, {wb_valid, wb_reg_write}); end
            total++; if (wb_rd !== 5'd3) begin bad++; $display("FAIL ld_hold_rd_%0d: got %0d exp 3", i, wb_rd); end
            total++; if (wb_data !== 64'h2A) begin bad++; $display("FAIL ld_hold_data_%0d: got %h exp 2a", i, wb_data); end
         end else begin
            total++; if ({wb_valid, wb_reg_write, wb_rd} !== {2'b11, 5'd5}) begin bad++; $display("FAIL ld_wb_ctl: got %h exp %h", {wb_valid, wb_reg_write, wb_rd}, {2'b11, 5'd5}); end
            total++; if (wb_data !== 64'h1122334455667788) begin bad++; $display("FAIL ld_wb_data: got %h exp 1122334455667788", wb_data); end
         end
      end
      total++; if (stalls != 3) begin bad++; $display("FAIL ld_stall_count: got %0d exp 3", stalls); end
   endtask

   task automatic test_back_to_back();
      // STURB at 0x45, same-cycle ack
      @(negedge clk);
      in_valid = 1; alu_result = 64'h45; write_data = 64'h1234_5678_9ABC_DEAB; rd = 0;
      reg_write = 0; mem_read = 0; mem_write = 1; byte_op = 1; dmem_ack = 1; dmem_rdata = 0;
      #1;
      total++; if ({dmem_req, dmem_we, stall_mem} !== 3'b110) begin bad++; $display("FAIL sb_ctl: got %b exp 110", {dmem_req, dmem_we, stall_mem}); end
      total++; if (dmem_be !== 8'h20) begin bad++; $display("FAIL sb_be: got %h exp 20", dmem_be); end
      total++; if (dmem_wdata !== 64'hABAB_ABAB_ABAB_ABAB) begin bad++; $display("FAIL sb_wdata: got %h exp abababababababab", dmem_wdata); end
      total++; if (dmem_addr !== 64'h40) begin bad++; $display("FAIL sb_addr: got %h exp 40", dmem_addr); end
      @(posedge clk); #1;
      total++; if ({wb_valid, wb_reg_write} !== 2'b10) begin bad++; $display("FAIL sb_wb: got %b exp 10", {wb_valid, wb_reg_write}); end
      // LDURB at 0x45, same-cycle ack
      @(negedge clk);
      rd = 7; reg_write = 1; mem_read = 1; mem_write = 0; byte_op = 1; dmem_ack = 1;
      dmem_rdata = 64'h0000_AB00_0000_0000;
      #1;
      total++; if ({dmem_req, dmem_we, stall_mem} !== 3'b100) begin bad++; $display("FAIL lb_ctl: got %b exp 100", {dmem_req, dmem_we, stall_mem}); end
      @(posedge clk); #1;
      total++; if (wb_data !== 64'hAB) begin bad++; $display("FAIL lb_data: got %h exp ab", wb_data); end
      total++; if ({wb_valid, wb_reg_write, wb_rd} !== {2'b11, 5'd7}) begin bad++; $display("FAIL lb_wb_ctl: got %h exp %h", {wb_valid, wb_reg_write, wb_rd}, {2'b11, 5'd7}); end
      // STUR at 0x48, same-cycle ack
      @(negedge clk);
      alu_result = 64'h48; write_data = 64'h0102030405060708; rd = 1;
      reg_write = 0; mem_read = 0; mem_write = 1; byte_op = 0; dmem_ack = 1;
      #1;
      total++; if ({dmem_req, dmem_we, stall_mem} !== 3'b110) begin bad++; $display("FAIL sd_ctl: got %b exp 110", {dmem_req, dmem_we, stall_mem}); end
      total++; if (dmem_be !== 8'hFF) begin bad++; $display("FAIL sd_be: got %h exp ff", dmem_be); end
      total++; if (dmem_wdata !== 64'h0102030405060708) begin bad++; $display("FAIL sd_wdata: got %h exp 0102030405060708", dmem_wdata); end
      @(posedge clk); #1;
      total++; if (wb_data !== 64'h48) begin bad++; $display("FAIL sd_wb_data: got %h exp 48", wb_data); end
   endtask

   task automatic test_misalign();
      @(negedge clk);
      in_valid = 1; alu_result = 64'h43; rd = 9; reg_write = 1; mem_read = 1; mem_write = 0;
      byte_op = 0; dmem_ack = 0;
      #1;
      total++; if ({dmem_req, stall_mem} !== 2'b00) begin bad++; $display("FAIL mis_req_stall: got %b exp 00", {dmem_req, stall_mem}); end
      total++; if (err_misalign !== 1'b0) begin bad++; $display("FAIL mis_err_pre: got %b exp 0", err_misalign); end
      @(posedge clk); #1;
      total++; if (err_misalign !== 1'b1) begin bad++; $display("FAIL mis_err: got %b exp 1", err_misalign); end
      total++; if (wb_reg_write !== 1'b0) begin bad++; $display("FAIL mis_wb_rw: got %b exp 0", wb_reg_write); end
      idle();
      total++; if (err_misalign !== 1'b1) begin bad++; $display("FAIL mis_sticky: got %b exp 1", err_misalign); end
   endtask

   task automatic test_timeout();
      int stalls = 0;
      for (int i = 0; i < TIMEOUT; i++) begin
         @(negedge clk);
         if (i == 0) begin
            in_valid = 1; alu_result = 64'h80; rd = 4; reg_write = 1; mem_read = 1; mem_write = 0;
            byte_op = 0; dmem_ack = 0; dmem_rdata = 64'hDEAD_BEEF_0000_1111;
         end
         #1;
         if (stall_mem === 1'b1) stalls++;
         total++; if ({dmem_req, stall_mem} !== {1'b1, i < TIMEOUT - 1}) begin bad++; $display("FAIL to_cyc_%0d: got %b exp %b", i, {dmem_req, stall_mem}, {1'b1, i < TIMEOUT - 1}); end
         @(posedge clk); #1;
         total++; if (wb_valid !== (i == TIMEOUT - 1)) begin bad++; $display("FAIL to_wb_valid_%0d: got %b exp %b", i, wb_valid, i == TIMEOUT - 1); end
         total++; if (err_timeout !== (i == TIMEOUT - 1)) begin bad++; $display("FAIL to_err_%0d: got %b exp %b", i, err_timeout, i == TIMEOUT - 1); end
      end
      total++; if (stalls != TIMEOUT - 1) begin bad++; $display("FAIL to_stall_count: got %0d exp %0d", stalls, TIMEOUT - 1); end
      total++; if (wb_data !== 64'd0) begin bad++; $display("FAIL to_wb_data: got %h exp 0", wb_data); end
      total++; if ({wb_reg_write, wb_rd} !== {1'b1, 5'd4}) begin bad++; $display("FAIL to_wb_rd: got %h exp %h", {wb_reg_write, wb_rd}, {1'b1, 5'd4}); end
      // stray late ack
      @(negedge clk);
      in_valid = 0; mem_read = 0; reg_write = 0; dmem_ack = 1; dmem_rdata = 64'h5555;
      #1;
      total++; if ({dmem_req, stall_mem} !== 2'b00) begin bad++; $display("FAIL stray_ctl: got %b exp 00", {dmem_req, stall_mem}); end
      @(posedge clk); #1;
      total++; if ({wb_valid, wb_reg_write, err_timeout, err_misalign} !== 4'b0011) begin bad++; $display("FAIL stray_state: got %b exp 0011", {wb_valid, wb_reg_write, err_timeout, err_misalign}); end
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk);
      in_valid = 1; alu_result = 64'h100; rd = 6; reg_write = 1; mem_read = 1; mem_write = 0;
      byte_op = 0; dmem_ack = 0;
      @(posedge clk);
      @(negedge clk); #1;
      total++; if (stall_mem !== 1'b1) begin bad++; $display("FAIL rmw_pre_stall: got %b exp 1", stall_mem); end
      #2 reset = 1;
      #1;
      total++; if ({dmem_req, stall_mem} !== 2'b00) begin bad++; $display("FAIL rmw_req_stall: got %b exp 00", {dmem_req, stall_mem}); end
      total++; if ({wb_valid, wb_reg_write, wb_rd} !== 7'd0) begin bad++; $display("FAIL rmw_wb_ctl: got %h exp 0", {wb_valid, wb_reg_write, wb_rd}); end
      total++; if (wb_data !== 64'd0) begin bad++; $display("FAIL rmw_wb_data: got %h exp 0", wb_data); end
      total++; if ({err_misalign, err_timeout} !== 2'b00) begin bad++; $display("FAIL rmw_err: got %b exp 00", {err_misalign, err_timeout}); end
      @(negedge clk);
      in_valid = 0; mem_read = 0; reg_write = 0;
      reset = 0;
      // fresh request acked one cycle later must stall exactly once
      @(negedge clk);
      in_valid = 1; alu_result = 64'h108; rd = 2; reg_write = 1; mem_read = 1; dmem_ack = 0;
      dmem_rdata = 64'h55;
      #1;
      total++; if (stall_mem !== 1'b1) begin bad++; $display("FAIL post_stall0: got %b exp 1", stall_mem); end
      @(posedge clk); #1;
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL post_bubble: got %b exp 0", wb_valid); end
      @(negedge clk);
      dmem_ack = 1;
      #1;
      total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL post_stall1: got %b exp 0", stall_mem); end
      @(posedge clk); #1;
      total++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd2, 64'h55}) begin bad++; $display("FAIL post_wb: got %h exp %h", {wb_valid, wb_rd, wb_data}, {1'b1, 5'd2, 64'h55}); end
   endtask

   initial begin
      test_reset();
      test_add();
      idle();
      test_load_wait();
      idle();
      test_back_to_back();
      idle();
      test_misalign();
      test_timeout();
      idle();
      test_reset_mid_wait();
      idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined CPU, directly downstream of the execute stage. It consumes the execute result held in the EX/MEM register (ALU result, store data, destination register, control bits), performs load/store transactions on a ready/acknowledge data-memory port, and owns the MEM/WB pipeline register. It stalls the upstream pipeline while a transaction is outstanding and supplies the forwarding information used by the execute-stage operand muxes.

## Interface
Parameters:
- TIMEOUT, 16, maximum cycles a request waits for `dmem_ack` before forced completion (≥2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX/MEM slot holds a real instruction.
- alu_result  in  64  ALU result; the byte address for loads and stores.
- write_data  in  64  store data (forwarded ReadData2).
- rd  in  5  destination register.
- mem_read, mem_write, reg_write  in  1 each  control bits.
- byte_op  in  1  1 = LDURB/STURB (8-bit), 0 = LDUR/STUR (64-bit).
- dmem_req  out  1  request strobe.
- dmem_we  out  1  1 = write.
- dmem_addr  out  64  `{alu_result[63:3], 3'b0}`.
- dmem_wdata  out  64  write data.
- dmem_be  out  8  byte enables.
- dmem_ack  in  1  transaction complete this cycle.
- dmem_rdata  in  64  read data, valid with `dmem_ack`.
- stall_mem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- fwd_mem_rd  out  5  `rd`, for the forwarding unit.
- fwd_mem_ok  out  1  `in_valid & reg_write & ~mem_read`; the MEM-stage value `alu_result` may be forwarded.
- wb_valid, wb_reg_write  out  1 each  MEM/WB register.
- wb_rd  out  5  MEM/WB register.
- wb_data  out  64  MEM/WB register; also the WB forwarding value.
- err_misalign, err_timeout  out  1 each  sticky error flags.

## Operation
- mem_op = `in_valid & (mem_read | mem_write)`. misalign = `mem_op & ~byte_op & (alu_result[2:0] != 0)`.
- FSM states:
  - IDLE → WAIT when `dmem_req & ~dmem_ack & ~timeout_hit`.
  - WAIT → IDLE on completion.
  - Completion = `dmem_ack`, or timeout_hit.
- dmem_req = `mem_op & ~misalign & ~reset`, in both IDLE and WAIT.
  - Address, data and byte enables are held stable by the stall, since the upstream register is frozen.
- Wait counter:
  - Counts cycles since the request was first asserted: 0 in the first cycle, +1 per WAIT cycle.
  - timeout_hit = `dmem_req & ~dmem_ack & (count == TIMEOUT-1)`.
- stall_mem = `dmem_req & ~dmem_ack & ~timeout_hit`.
- Store enables and data:
  - 64-bit store: `dmem_be = 8'hFF`, `dmem_wdata = write_data`.
  - Byte store: `dmem_be = 1 << alu_result[2:0]`, `dmem_wdata = {8{write_data[7:0]}}`.
- Load data:
  - 64-bit load: `dmem_rdata`.
  - Byte load: `dmem_rdata` byte lane `alu_result[2:0]`, zero-extended.
  - Timeout: the load value is 0.
- MEM/WB update on every edge where stall_mem = 0:
  - wb_valid ← in_valid.
  - wb_rd ← rd.
  - wb_reg_write ← `in_valid & reg_write & ~misalign`.
  - wb_data ← load value if mem_read, else alu_result.
- While stall_mem = 1, a bubble enters MEM/WB: wb_valid ← 0, wb_reg_write ← 0; wb_data and wb_rd hold.
- Misaligned 64-bit access:
  - No request is issued and no stall occurs.
  - Retires as a bubble with reg_write suppressed.
  - Sets err_misalign.
- Timeout sets err_timeout. Both error flags clear only on reset.
- `dmem_ack` while `dmem_req = 0` is ignored; a late ack after a timeout has no effect.

## Timing
- Reset state:
  - FSM in IDLE, counter 0.
  - wb_valid, wb_reg_write, wb_rd, wb_data = 0.
  - err_misalign, err_timeout = 0.
  - dmem_req = 0 and stall_mem = 0 while reset is high.
- Memory that acks in the request cycle: zero stall cycles.
- Ack k cycles after the first request cycle: stall_mem is high for exactly k cycles, and MEM/WB captures on the ack edge.
- Timeout: stall_mem is high for TIMEOUT-1 cycles; MEM/WB captures on the edge of cycle TIMEOUT-1.
- Non-memory instructions: one-cycle latency into MEM/WB.
- fwd_* outputs are combinational from the inputs.
- Reset asserted mid-WAIT:
  - Everything returns to reset values immediately.
  - The outstanding transaction is abandoned.

## Test plan
- ADD result 0x2A, rd=3, reg_write=1, no mem op -> next edge: wb_valid=1, wb_reg_write=1, wb_rd=3, wb_data=0x2A, stall_mem=0 throughout; fwd_mem_ok=1 during the MEM cycle.
- LDUR at 0x40, memory acks 3 cycles after the request with rdata 0x1122334455667788 -> stall_mem high exactly 3 cycles; 3 bubbles with wb_valid=0; then wb_data=0x1122334455667788.
- STURB at 0x45, write_data=0xAB, same-cycle ack -> dmem_be=0x20, dmem_wdata=0xABAB…AB, dmem_we=1, no stall. Then LDURB at 0x45 with rdata 0x0000AB0000000000 -> wb_data=0xAB.
- LDUR at 0x43 -> dmem_req never asserts, err_misalign=1, wb_reg_write=0, no stall.
- LDUR, ack never arrives, TIMEOUT=16 -> stall 15 cycles, then wb_data=0, err_timeout=1; a stray ack afterwards changes nothing.
- Reset pulse during WAIT -> dmem_req, stall_mem, wb_* and error flags are 0 immediately, before the next clock edge.
